tc_to_qsm: RTL
==============

// Module: tc_to_qsm
// PURPOSE
//  Streaming converter: two's-complement fixed-point samples (ADC/NCO side) -> sign-magnitude Qm.Q words for the adder datapath.
//  Negates negatives to magnitude, realigns fractional point, rounds, saturates, never emits negative zero.
//  Valid/ready on both sides; 2-stage pipeline; per-sample saturation flag plus sticky saturation counter.
// PARAMETERS
//  N        16   output word width (bit N-1 = sign, N-2:0 = magnitude)
//  Q        9    output fractional bits
//  W_IN     12   input two's-complement width
//  FRAC_IN  11   input fractional bits; shift S = Q-FRAC_IN (S>0 left, S<0 right w/ rounding, 0 pass)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       input sample valid
//  in_ready   out  1       converter can accept (transfer when in_valid & in_ready)
//  in_data    in   W_IN    two's-complement sample
//  out_valid  out  1       out_data/out_sat valid
//  out_ready  in   1       consumer accepts (transfer when out_valid & out_ready)
//  out_data   out  N       sign-magnitude Q-format result
//  out_sat    out  1       this sample was clipped
//  sat_count  out  16      count of accepted saturated outputs, sticks at 0xFFFF
//  clr_sat    in   1       synchronous clear of sat_count
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): s1/s2 valid=0, out_data=0, out_sat=0, sat_count=0; in_ready=0 while rst_n=0.
//  - Stage1 (capture): sign=in_data[W_IN-1]; mag = sign ? -in_data : in_data, computed W_IN+1 bits wide so -2^(W_IN-1) -> 2^(W_IN-1) exact.
//  - Stage2 (align): S<0: mag_r=(mag + 2^(-S-1)) >> -S (round half up on magnitude = symmetric about zero); S>0: mag << S; width
//    wide enough for no intermediate loss. If mag_r > 2^(N-1)-1: magnitude = 2^(N-1)-1, out_sat=1. If magnitude==0: sign forced 0.
//  - Latency: 2 cycles input transfer -> out_valid with no backpressure; throughput 1 sample/cycle.
//  - Handshake: stage k loads when empty or advancing; s2 advances on out_ready; in_ready = !s1_valid | s1_advance (combinational
//    from regs and out_ready, no in_valid dependence). out_data/out_sat held stable while out_valid & !out_ready. No drop, no dup.
//  - Order preserved; bubbles collapse when downstream stalls (both stages fill, then in_ready=0).
//  - sat_count: +1 on each output transfer with out_sat=1, saturates at 0xFFFF. clr_sat wins over a simultaneous increment (result 0).
//  - Reset mid-stream: in-flight samples discarded, no output after rst_n rises until new input.
// STRUCTURE
//  - Shared header qformat_defs.vh: default N/Q, sign-bit index macro, MAX_MAG(N) localparam; reused by adder/multiplier blocks.
//  - One sub-module tc_to_qsm_align: combinational shift+round+saturate+zero-sign cleanup (S, widths as params); top holds pipeline
//    regs, handshake, counter.
// TESTING (defaults unless noted; S=-2)
//  1 in=0x400 (+0.5), out_ready=1 -> 2 cycles later out_data=0x0100, out_sat=0; in=0xC00 (-0.5) -> 0x8100.
//  2 in=0x800 (-1.0) -> 0x8200; in=0xFFF (-1 LSB) -> 0x0000 (no neg zero); in=0x002 -> 0x0001; in=0xFFE -> 0x8001.
//  3 N=12,Q=11,W_IN=12,FRAC_IN=11: in=0x800 -> out 0xFFF, out_sat=1, sat_count 0->1; in=0x7FF -> 0x7FF, sat=0.
//  4 Stream 0..99 ramp, random out_ready (~50%) -> outputs in order, none lost/duplicated, out_data stable during stall,
//    in_ready=0 only when both stages full and out_ready=0.
//  5 sat_count preload to 0xFFFE via repeated sat samples -> sticks at 0xFFFF; clr_sat same cycle as sat transfer -> 0.
//  6 Assert rst_n low with both stages full -> out_valid=0 immediately, sat_count=0; first new sample appears 2 cycles after entry.

Source files
------------

// File: rtl/tc_to_qsm_pkg.sv
// Shared Q-format definitions for the sign-magnitude datapath blocks
// (converter, adder, multiplier): default word geometry, sign-bit index,
// maximum representable magnitude and the input-to-output alignment shift.
package tc_to_qsm_pkg;

   localparam int QF_N_DEF       = 16;
   localparam int QF_Q_DEF       = 9;
   localparam int QF_W_IN_DEF    = 12;
   localparam int QF_FRAC_IN_DEF = 11;

   localparam int SAT_CNT_W      = 16;

   // Bit index of the sign in an n-bit sign-magnitude word.
   function automatic int qf_sign_idx(input int n);
      return n - 1;
   endfunction

   // Largest magnitude held by an n-bit sign-magnitude word (2^(n-1)-1).
   function automatic longint qf_max_mag(input int n);
      return (longint'(1) << (n - 1)) - 1;
   endfunction

   // Alignment shift: positive = shift left, negative = shift right with rounding.
   function automatic int qf_shift(input int q_out, input int frac_in);
      return q_out - frac_in;
   endfunction

endpackage

// File: rtl/tc_to_qsm_align.sv
// Combinational alignment of an unsigned magnitude into the output Q format:
// shift (round half up on the magnitude when shifting right), clip to the
// largest representable magnitude, and drop the sign on a zero result.
module tc_to_qsm_align
   import tc_to_qsm_pkg::*;
#(
   parameter int N   = QF_N_DEF,
   parameter int W_M = QF_W_IN_DEF + 1,
   parameter int S   = qf_shift(QF_Q_DEF, QF_FRAC_IN_DEF)
) (
   input  logic           sign_i,
   input  logic [W_M-1:0] mag_i,
   output logic [N-1:0]   data_o,
   output logic           sat_o
);

   localparam int SR  = (S < 0) ? -S : 0;
   localparam int SL  = (S > 0) ? S : 0;
   // One spare bit above the shifted magnitude absorbs the rounding carry.
   localparam int W_X = W_M + SL + 1;
   localparam int W_C = (W_X > N) ? W_X : N;
   localparam int SGN = qf_sign_idx(N);
   localparam logic [W_C-1:0] MAX_C = W_C'(qf_max_mag(N));

   logic [W_C-1:0] ext;
   logic [W_C-1:0] shifted;
   logic [N-2:0]   mag_o;
   logic           sign_o;

   assign ext = W_C'(mag_i);

   generate
      if (S < 0) begin : g_right
         assign shifted = (ext + (W_C'(1) << (SR - 1))) >> SR;
      end else if (S > 0) begin : g_left
         assign shifted = ext << SL;
      end else begin : g_pass
         assign shifted = ext;
      end
   endgenerate

   // Saturate, then clear the sign of a zero magnitude so -0 never escapes.
   always_comb begin
      sat_o  = (shifted > MAX_C);
      mag_o  = sat_o ? MAX_C[N-2:0] : shifted[N-2:0];
      sign_o = sign_i & (mag_o != '0);
      data_o = '0;
      data_o[SGN]   = sign_o;
      data_o[N-2:0] = mag_o;
   end

endmodule

// File: rtl/tc_to_qsm.sv
// Two's-complement fixed-point to sign-magnitude Q-format stream converter.
// Stage 1 captures sign and exact magnitude; stage 2 holds the aligned,
// rounded, saturated word. Valid/ready on both sides, one sample per cycle,
// plus a sticky saturation event counter.
module tc_to_qsm
   import tc_to_qsm_pkg::*;
#(
   parameter int N       = QF_N_DEF,
   parameter int Q       = QF_Q_DEF,
   parameter int W_IN    = QF_W_IN_DEF,
   parameter int FRAC_IN = QF_FRAC_IN_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W_IN-1:0]      in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_data,
   output logic                 out_sat,
   output logic [SAT_CNT_W-1:0] sat_count,
   input  logic                 clr_sat
);

   localparam int S   = qf_shift(Q, FRAC_IN);
   // One extra bit so the most negative input has an exact magnitude.
   localparam int W_M = W_IN + 1;

   logic                 s1_valid_q, s1_valid_d;
   logic                 s1_sign_q,  s1_sign_d;
   logic [W_M-1:0]       s1_mag_q,   s1_mag_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [N-1:0]         s2_data_q,  s2_data_d;
   logic                 s2_sat_q,   s2_sat_d;
   logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;

   logic                 s2_load;
   logic                 s1_adv;
   logic                 s1_load;
   logic                 in_fire;
   logic [W_M-1:0]       in_ext;
   logic [W_M-1:0]       in_mag;
   logic [N-1:0]         al_data;
   logic                 al_sat;

   tc_to_qsm_align #(
      .N   (N),
      .W_M (W_M),
      .S   (S)
   ) u_align (
      .sign_i (s1_sign_q),
      .mag_i  (s1_mag_q),
      .data_o (al_data),
      .sat_o  (al_sat)
   );

   // Handshake: each stage loads when empty or when its content moves on.
   // in_ready depends only on registers and out_ready, never on in_valid.
   always_comb begin
      s2_load  = !s2_valid_q | out_ready;
      s1_adv   = s1_valid_q & s2_load;
      s1_load  = !s1_valid_q | s1_adv;
      in_ready = rst_n & s1_load;
      in_fire  = in_valid & s1_load;
   end

   // Stage 1 next state: sign and magnitude of the accepted sample.
   always_comb begin
      in_ext     = {in_data[W_IN-1], in_data};
      in_mag     = in_ext[W_M-1] ? (~in_ext + W_M'(1)) : in_ext;
      s1_valid_d = s1_load ? in_valid : s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_mag_d   = s1_mag_q;
      if (in_fire) begin
         s1_sign_d = in_data[W_IN-1];
         s1_mag_d  = in_mag;
      end
   end

   // Stage 2 next state: output payload only changes when stage 1 advances,
   // so the word is held steady while the consumer stalls.
   always_comb begin
      s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_sat_d   = s2_sat_q;
      if (s1_adv) begin
         s2_data_d = al_data;
         s2_sat_d  = al_sat;
      end
   end

   // Saturation counter: counts clipped samples actually delivered, sticks
   // at all-ones; a clear takes priority over a same-cycle increment.
   always_comb begin
      sat_count_d = sat_count_q;
      if (clr_sat) begin
         sat_count_d = '0;
      end else if (s2_valid_q && out_ready && s2_sat_q && (sat_count_q != '1)) begin
         sat_count_d = sat_count_q + SAT_CNT_W'(1);
      end
   end

   // Pipeline and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_mag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_data_q   <= '0;
         s2_sat_q    <= 1'b0;
         sat_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_mag_q    <= s1_mag_d;
         s2_valid_q  <= s2_valid_d;
         s2_data_q   <= s2_data_d;
         s2_sat_q    <= s2_sat_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_sat   = s2_sat_q;
   assign sat_count = sat_count_q;

endmodule
